ddr5_cmd_sequencer: RTL and testbench

Synthesizable DDR5 command sequencer that sits between the 16-entry request scheduler queue and the DIMM command bus. It accepts one decoded request at a time and tracks the open row of all 32 banks (8 bank groups x 4 banks). It emits the two-cycle ACT/RD/WR command pairs and single-cycle PRE, each gated by per-bank and per-request JEDEC timing counters. It pulses completion when the data burst ends.

---
 rtl/ddr5_cmd_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ddr5_cmd_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr5_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ddr5_cmd_sequencer
// Purpose  : One-request-at-a-time DDR5 ACT/RD/WR/PRE sequencer with per-bank
//            open-row tracking and JEDEC timing counters.
//            Optional macro CLOSED_PAGE_EN selects closed-page policy.
// Revision : 1.0
// ============================================================================
module ddr5_cmd_sequencer #(
    parameter int T_RCD   = 39,
    parameter int T_RP    = 39,
    parameter int T_RAS   = 76,
    parameter int T_CAS   = 40,
    parameter int T_CWD   = 38,
    parameter int T_BURST = 8,
    parameter int T_RTP   = 18,
    parameter int T_WR    = 30,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_bg,
    input  logic [1:0]  req_bank,
    input  logic [15:0] req_row,
    input  logic [9:0]  req_col,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [15:0] cmd_addr,
    output logic        done_valid,
    output logic        done_write,
    output logic        busy
);

    localparam int c_NB = 32;

    localparam logic [3:0] c_ST_IDLE      = 4'd0;
    localparam logic [3:0] c_ST_PRE_WAIT  = 4'd1;
    localparam logic [3:0] c_ST_PRE       = 4'd2;
    localparam logic [3:0] c_ST_RP_WAIT   = 4'd3;
    localparam logic [3:0] c_ST_ACT0      = 4'd4;
    localparam logic [3:0] c_ST_ACT1      = 4'd5;
    localparam logic [3:0] c_ST_RCD_WAIT  = 4'd6;
    localparam logic [3:0] c_ST_COL0      = 4'd7;
    localparam logic [3:0] c_ST_COL1      = 4'd8;
    localparam logic [3:0] c_ST_DATA_WAIT = 4'd9;
    localparam logic [3:0] c_ST_DONE      = 4'd10;

    localparam logic [2:0] c_CMD_ACT0 = 3'd0;
    localparam logic [2:0] c_CMD_ACT1 = 3'd1;
    localparam logic [2:0] c_CMD_RD0  = 3'd2;
    localparam logic [2:0] c_CMD_RD1  = 3'd3;
    localparam logic [2:0] c_CMD_WR0  = 3'd4;
    localparam logic [2:0] c_CMD_WR1  = 3'd5;
    localparam logic [2:0] c_CMD_PRE  = 3'd6;
    localparam logic [2:0] c_CMD_NOP  = 3'd7;

    localparam logic [CNT_W-1:0] c_RCD     = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0] c_RP      = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] c_RAS     = CNT_W'(T_RAS);
    localparam logic [CNT_W-1:0] c_RTP     = CNT_W'(T_RTP);
    localparam logic [CNT_W-1:0] c_RD_DATA = CNT_W'(T_CAS + T_BURST);
    localparam logic [CNT_W-1:0] c_WR_DATA = CNT_W'(T_CWD + T_BURST);
    localparam logic [CNT_W-1:0] c_WR_HOLD = CNT_W'(T_CWD + T_BURST + T_WR);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

`ifdef CLOSED_PAGE_EN
    localparam bit c_CLOSED = 1'b1;
`else
    localparam bit c_CLOSED = 1'b0;
`endif

    generate
        if (T_RCD >= (1 << CNT_W) || T_RP >= (1 << CNT_W) || T_RAS >= (1 << CNT_W) ||
            T_CAS >= (1 << CNT_W) || T_CWD >= (1 << CNT_W) || T_BURST >= (1 << CNT_W) ||
            T_RTP >= (1 << CNT_W) || T_WR >= (1 << CNT_W) ||
            (T_CWD + T_BURST + T_WR) >= (1 << CNT_W)) begin : g_param_bad
            $error("ddr5_cmd_sequencer: timing parameter does not fit in CNT_W bits");
        end
    endgenerate

    logic [3:0]       r_state, w_next;
    logic             r_write;
    logic [4:0]       r_idx;
    logic [15:0]      r_row;
    logic [9:0]       r_col;
    logic [CNT_W-1:0] r_tmr, w_tmr_nxt;

    logic [c_NB-1:0]  w_bank_open;
    logic [15:0]      w_bank_row [c_NB];
    logic [CNT_W-1:0] w_bank_cnt [c_NB];

    logic             w_xfer, w_in_idle, w_write, w_open, w_hit, w_pre_ok, w_tmr_ok;
    logic [4:0]       w_idx;
    logic [15:0]      w_row;
    logic [9:0]       w_col;

    // In IDLE the live request fields drive decisions, otherwise the latched copy.
    assign w_xfer    = req_valid && req_ready;
    assign w_in_idle = (r_state == c_ST_IDLE);
    assign w_idx     = w_in_idle ? {req_bg, req_bank} : r_idx;
    assign w_write   = w_in_idle ? req_write : r_write;
    assign w_row     = w_in_idle ? req_row : r_row;
    assign w_col     = w_in_idle ? req_col : r_col;
    assign w_open    = !c_CLOSED && w_bank_open[w_idx];
    assign w_hit     = w_open && (w_bank_row[w_idx] == req_row);
    assign w_pre_ok  = (w_bank_cnt[w_idx] <= c_ONE);
    assign w_tmr_ok  = (r_tmr <= c_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_tmr   <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_next;
            r_tmr   <= w_tmr_nxt;
            if (w_xfer) begin
                r_write <= req_write;
                r_idx   <= {req_bg, req_bank};
                r_row   <= req_row;
                r_col   <= req_col;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_xfer) begin
                    if (!w_open)      w_next = c_ST_ACT0;
                    else if (w_hit)   w_next = c_ST_COL0;
                    else if (w_pre_ok) w_next = c_ST_PRE;
                    else              w_next = c_ST_PRE_WAIT;
                end
            end
            c_ST_PRE_WAIT:  if (w_pre_ok) w_next = c_ST_PRE;
            c_ST_PRE: begin
                if (!w_tmr_ok)    w_next = c_ST_RP_WAIT;
                else if (c_CLOSED) w_next = c_ST_IDLE;
                else              w_next = c_ST_ACT0;
            end
            c_ST_RP_WAIT:   if (w_tmr_ok) w_next = c_CLOSED ? c_ST_IDLE : c_ST_ACT0;
            c_ST_ACT0:      w_next = c_ST_ACT1;
            c_ST_ACT1:      w_next = w_tmr_ok ? c_ST_COL0 : c_ST_RCD_WAIT;
            c_ST_RCD_WAIT:  if (w_tmr_ok) w_next = c_ST_COL0;
            c_ST_COL0:      w_next = c_ST_COL1;
            c_ST_COL1:      w_next = w_tmr_ok ? c_ST_DONE : c_ST_DATA_WAIT;
            c_ST_DATA_WAIT: if (w_tmr_ok) w_next = c_ST_DONE;
            c_ST_DONE: begin
                if (!c_CLOSED)     w_next = c_ST_IDLE;
                else if (w_pre_ok) w_next = c_ST_PRE;
                else               w_next = c_ST_PRE_WAIT;
            end
            default:        w_next = c_ST_IDLE;
        endcase
    end

    // Request timer holds the cycles left until the next gated state may start.
    always_comb begin
        w_tmr_nxt = (r_tmr != '0) ? r_tmr - c_ONE : '0;
        case (w_next)
            c_ST_ACT0: w_tmr_nxt = c_RCD;
            c_ST_PRE:  w_tmr_nxt = c_RP;
            c_ST_COL0: w_tmr_nxt = w_write ? c_WR_DATA : c_RD_DATA;
            default:   ;
        endcase
    end

    generate
        for (genvar b = 0; b < c_NB; b++) begin : g_bank
            logic             r_open;
            logic [15:0]      r_brow;
            logic [CNT_W-1:0] r_cnt;
            logic             w_sel;
            logic [CNT_W-1:0] w_dec, w_hold;

            assign w_sel  = (w_idx == 5'(b));
            assign w_dec  = (r_cnt != '0) ? r_cnt - c_ONE : '0;
            assign w_hold = r_write ? c_WR_HOLD : c_RTP;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_open <= 1'b0;
                    r_brow <= '0;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= w_dec;
                    if (w_sel) begin
                        case (w_next)
                            c_ST_ACT0: begin
                                r_open <= 1'b1;
                                r_brow <= w_row;
                                r_cnt  <= c_RAS;
                            end
                            c_ST_PRE:  r_open <= 1'b0;
                            c_ST_COL1: r_cnt  <= (w_dec > w_hold) ? w_dec : w_hold;
                            default:   ;
                        endcase
                    end
                end
            end

            assign w_bank_open[b] = r_open;
            assign w_bank_row[b]  = r_brow;
            assign w_bank_cnt[b]  = r_cnt;
        end
    endgenerate

    logic [2:0]  w_cmd_code;
    logic [15:0] w_cmd_addr;

    always_comb begin
        w_cmd_code = c_CMD_NOP;
        w_cmd_addr = '0;
        case (w_next)
            c_ST_ACT0: begin w_cmd_code = c_CMD_ACT0; w_cmd_addr = w_row; end
            c_ST_ACT1: begin w_cmd_code = c_CMD_ACT1; w_cmd_addr = w_row; end
            c_ST_COL0: begin
                w_cmd_code = w_write ? c_CMD_WR0 : c_CMD_RD0;
                w_cmd_addr = {6'b0, w_col};
            end
            c_ST_COL1: begin
                w_cmd_code = w_write ? c_CMD_WR1 : c_CMD_RD1;
                w_cmd_addr = {6'b0, w_col};
            end
            c_ST_PRE:  w_cmd_code = c_CMD_PRE;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_code   <= c_CMD_NOP;
            cmd_bg     <= '0;
            cmd_bank   <= '0;
            cmd_addr   <= '0;
            done_valid <= 1'b0;
            done_write <= 1'b0;
            busy       <= 1'b0;
        end else begin
            req_ready  <= (w_next == c_ST_IDLE);
            cmd_valid  <= (w_cmd_code != c_CMD_NOP);
            cmd_code   <= w_cmd_code;
            cmd_bg     <= (w_cmd_code != c_CMD_NOP) ? w_idx[4:2] : 3'd0;
            cmd_bank   <= (w_cmd_code != c_CMD_NOP) ? w_idx[1:0] : 2'd0;
            cmd_addr   <= w_cmd_addr;
            done_valid <= (w_next == c_ST_DONE);
            done_write <= (w_next == c_ST_DONE) && w_write;
            busy       <= (w_next != c_ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr5_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr5_cmd_sequencer
// Purpose  : Directed self-checking bench for ddr5_cmd_sequencer.
// Revision : 1.0
// ============================================================================
module tb_ddr5_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_bg = '0;
    logic [1:0]  req_bank = '0;
    logic [15:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [15:0] cmd_addr;
    logic        done_valid;
    logic        done_write;
    logic        busy;

    ddr5_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bg(cmd_bg),
        .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
        .done_valid(done_valid), .done_write(done_write), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Offsets (cycles after the transfer cycle) of the first occurrence of each event.
    int          o_act0, o_act1, o_col0, o_col1, o_pre, o_done, o_ready, n_act0, n_pre;
    logic [2:0]  col0_code, col1_code, act_bg;
    logic [1:0]  act_bank;
    logic [15:0] act_addr, col_addr;
    logic        done_w;

    task automatic run_req(input logic wr, input logic [2:0] bg, input logic [1:0] bk,
                           input logic [15:0] row, input logic [9:0] col);
        int  c;
        int  off;
        bit  got;
        o_act0 = -1; o_act1 = -1; o_col0 = -1; o_col1 = -1;
        o_pre = -1; o_done = -1; o_ready = -1; n_act0 = 0; n_pre = 0;
        col0_code = 3'd7; col1_code = 3'd7; act_bg = '0; act_bank = '0;
        act_addr = '0; col_addr = '0; done_w = 1'b0;
        req_write = wr; req_bg = bg; req_bank = bk; req_row = row; req_col = col;
        req_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            if (req_ready === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept: req_ready stayed %b, required 1 within 50 cycles", req_ready);
            req_valid = 1'b0;
            return;
        end
        c = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            off = cyc - c;
            if (cmd_valid === 1'b1) begin
                case (cmd_code)
                    3'd0: begin
                        if (o_act0 < 0) begin
                            o_act0 = off; act_addr = cmd_addr; act_bg = cmd_bg; act_bank = cmd_bank;
                        end
                        n_act0++;
                    end
                    3'd1: if (o_act1 < 0) o_act1 = off;
                    3'd2, 3'd4: if (o_col0 < 0) begin
                        o_col0 = off; col0_code = cmd_code; col_addr = cmd_addr;
                    end
                    3'd3, 3'd5: if (o_col1 < 0) begin o_col1 = off; col1_code = cmd_code; end
                    3'd6: begin if (o_pre < 0) o_pre = off; n_pre++; end
                    default: ;
                endcase
            end
            if (done_valid === 1'b1) begin o_done = off; done_w = done_write; end
            if (o_done >= 0 && req_ready === 1'b1) begin o_ready = off; break; end
            @(negedge clk);
        end
        checks++;
        if (o_ready < 0) begin
            errors++;
            $display("FAIL complete: done offset %0d ready offset %0d, required completion within 400 cycles",
                     o_done, o_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        checks++; if (cmd_code !== 3'd7) begin errors++; $display("FAIL rst_code: got %0d want 7", cmd_code); end
        checks++;
        if ({cmd_valid, done_valid, done_write, busy} !== 4'b0) begin
            errors++; $display("FAIL rst_flags: got %b want 0000", {cmd_valid, done_valid, done_write, busy});
        end
        checks++;
        if ({cmd_bg, cmd_bank, cmd_addr} !== 21'd0) begin
            errors++; $display("FAIL rst_addr: got %h want 0", {cmd_bg, cmd_bank, cmd_addr});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_empty_read;
        run_req(1'b0, 3'd2, 2'd1, 16'h1234, 10'h05A);
        checks++; if (o_act0 !== 1)  begin errors++; $display("FAIL empty_act0: got %0d want 1", o_act0); end
        checks++; if (o_act1 !== 2)  begin errors++; $display("FAIL empty_act1: got %0d want 2", o_act1); end
        checks++; if (act_addr !== 16'h1234) begin errors++; $display("FAIL empty_act_addr: got %h want 1234", act_addr); end
        checks++;
        if ({act_bg, act_bank} !== 5'b010_01) begin
            errors++; $display("FAIL empty_act_bank: got %b want 01001", {act_bg, act_bank});
        end
        checks++; if (o_col0 !== 40) begin errors++; $display("FAIL empty_rd0: got %0d want 40", o_col0); end
        checks++; if (col0_code !== 3'd2) begin errors++; $display("FAIL empty_rd0_code: got %0d want 2", col0_code); end
        checks++; if (o_col1 !== 41) begin errors++; $display("FAIL empty_rd1: got %0d want 41", o_col1); end
        checks++; if (col1_code !== 3'd3) begin errors++; $display("FAIL empty_rd1_code: got %0d want 3", col1_code); end
        checks++; if (col_addr !== 16'h005A) begin errors++; $display("FAIL empty_col_addr: got %h want 005a", col_addr); end
        checks++; if (o_done !== 88) begin errors++; $display("FAIL empty_done: got %0d want 88", o_done); end
        checks++; if (done_w !== 1'b0) begin errors++; $display("FAIL empty_done_write: got %b want 0", done_w); end
        checks++; if (o_ready !== 89) begin errors++; $display("FAIL empty_ready: got %0d want 89", o_ready); end
        checks++; if (n_pre !== 0) begin errors++; $display("FAIL empty_no_pre: got %0d want 0", n_pre); end
    endtask

    task automatic test_hit_read;
        run_req(1'b0, 3'd2, 2'd1, 16'h1234, 10'h05A);
        checks++; if (n_act0 !== 0) begin errors++; $display("FAIL hit_no_act: got %0d want 0", n_act0); end
        checks++; if (o_col0 !== 1) begin errors++; $display("FAIL hit_rd0: got %0d want 1", o_col0); end
        checks++; if (o_col1 !== 2) begin errors++; $display("FAIL hit_rd1: got %0d want 2", o_col1); end
        checks++; if (o_done !== 49) begin errors++; $display("FAIL hit_done: got %0d want 49", o_done); end
    endtask

    task automatic test_miss_read;
        run_req(1'b0, 3'd2, 2'd1, 16'h0001, 10'h000);
        checks++; if (o_pre !== 1) begin errors++; $display("FAIL miss_pre: got %0d want 1", o_pre); end
        checks++; if (o_act0 !== 40) begin errors++; $display("FAIL miss_act0: got %0d want 40", o_act0); end
        checks++; if (o_act1 !== 41) begin errors++; $display("FAIL miss_act1: got %0d want 41", o_act1); end
        checks++; if (act_addr !== 16'h0001) begin errors++; $display("FAIL miss_act_addr: got %h want 0001", act_addr); end
        checks++; if (o_col0 !== 79) begin errors++; $display("FAIL miss_rd0: got %0d want 79", o_col0); end
        checks++; if (o_done !== 127) begin errors++; $display("FAIL miss_done: got %0d want 127", o_done); end
    endtask

    task automatic test_write_miss;
        run_req(1'b1, 3'd5, 2'd3, 16'h00AA, 10'h3FF);
        checks++; if (o_act0 !== 1) begin errors++; $display("FAIL wr_act0: got %0d want 1", o_act0); end
        checks++; if (o_col0 !== 40) begin errors++; $display("FAIL wr_wr0: got %0d want 40", o_col0); end
        checks++; if (col0_code !== 3'd4) begin errors++; $display("FAIL wr_wr0_code: got %0d want 4", col0_code); end
        checks++; if (col1_code !== 3'd5) begin errors++; $display("FAIL wr_wr1_code: got %0d want 5", col1_code); end
        checks++; if (col_addr !== 16'h03FF) begin errors++; $display("FAIL wr_col_addr: got %h want 03ff", col_addr); end
        checks++; if (o_done !== 86) begin errors++; $display("FAIL wr_done: got %0d want 86", o_done); end
        checks++; if (done_w !== 1'b1) begin errors++; $display("FAIL wr_done_write: got %b want 1", done_w); end
        checks++; if (o_ready !== 87) begin errors++; $display("FAIL wr_ready: got %0d want 87", o_ready); end
        // Accepted at c+87; write recovery holds PRE until c+117.
        run_req(1'b0, 3'd5, 2'd3, 16'h00AB, 10'h001);
        checks++; if (o_pre !== 30) begin errors++; $display("FAIL wmiss_pre: got %0d want 30", o_pre); end
        checks++; if (n_pre !== 1) begin errors++; $display("FAIL wmiss_pre_count: got %0d want 1", n_pre); end
        checks++; if (o_act0 !== 69) begin errors++; $display("FAIL wmiss_act0: got %0d want 69", o_act0); end
        checks++; if (o_done !== 156) begin errors++; $display("FAIL wmiss_done: got %0d want 156", o_done); end
    endtask

    task automatic test_reset_mid;
        bit got;
        req_write = 1'b0; req_bg = 3'd1; req_bank = 2'd0; req_row = 16'h0777; req_col = 10'h011;
        req_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            if (req_ready === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
        checks++; if (cmd_code !== 3'd7) begin errors++; $display("FAIL mid_wait_nop: got %0d want 7", cmd_code); end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, busy, cmd_valid, done_valid} !== 4'b0) begin
            errors++; $display("FAIL mid_rst_flags: got %b want 0000", {req_ready, busy, cmd_valid, done_valid});
        end
        checks++; if (cmd_code !== 3'd7) begin errors++; $display("FAIL mid_rst_code: got %0d want 7", cmd_code); end
        rst = 1'b0;
        run_req(1'b0, 3'd1, 2'd0, 16'h0777, 10'h011);
        checks++; if (n_pre !== 0) begin errors++; $display("FAIL mid_no_pre: got %0d want 0", n_pre); end
        checks++; if (o_act0 !== 1) begin errors++; $display("FAIL mid_act0: got %0d want 1", o_act0); end
        checks++; if (o_col0 !== 40) begin errors++; $display("FAIL mid_rd0: got %0d want 40", o_col0); end
        checks++; if (o_done !== 88) begin errors++; $display("FAIL mid_done: got %0d want 88", o_done); end
    endtask

    task automatic test_closed_page;
        run_req(1'b0, 3'd2, 2'd1, 16'h1234, 10'h05A);
        checks++; if (o_act0 !== 1) begin errors++; $display("FAIL cp_act0: got %0d want 1", o_act0); end
        checks++; if (o_col0 !== 40) begin errors++; $display("FAIL cp_rd0: got %0d want 40", o_col0); end
        checks++; if (o_done !== 88) begin errors++; $display("FAIL cp_done: got %0d want 88", o_done); end
        checks++; if (o_pre !== 89) begin errors++; $display("FAIL cp_pre: got %0d want 89", o_pre); end
        checks++; if (o_ready !== 128) begin errors++; $display("FAIL cp_ready: got %0d want 128", o_ready); end
        run_req(1'b0, 3'd2, 2'd1, 16'h1234, 10'h05A);
        checks++; if (o_act0 !== 1) begin errors++; $display("FAIL cp_again_act0: got %0d want 1", o_act0); end
        checks++; if (o_done !== 88) begin errors++; $display("FAIL cp_again_done: got %0d want 88", o_done); end
    endtask

    initial begin
        test_reset;
`ifdef CLOSED_PAGE_EN
        test_closed_page;
`else
        test_empty_read;
        test_hit_read;
        test_miss_read;
        test_write_miss;
        test_reset_mid;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
